// File: rtl/alu_share_arb.sv
// Purpose : shares one combinational ALU between an EX-stage port (0) and a helper-unit port (1).
// Latency : request accepted in cycle N gives resp_valid in cycle N+2; next accept no earlier than N+3.
// Backpress: a held response (resp_ready low) blocks both request ports; losers are not latched.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_*_0 / req_*_1             request valid/ready plus ctrl, operands and shift amount per port
//   resp_valid_x / resp_ready_x   per-port response handshake; resp_r/cout/ovf/ze/err are shared
//   alu_ctrl/a/b/shamt            registered operands driven to the external ALU
//   alu_r/cout/ovf/ze             ALU result and flags, captured one cycle after issue
//
// Optional feature macro: ALU_SHARE_ARB_ILLEGAL_CHK_EN
//   defined   : ctrl[3]=1 codes bypass the ALU and answer one cycle after accept with resp_err=1
//   undefined : every code goes to the ALU and resp_err is tied low
module alu_share_arb #(
    parameter int ARB_MODE = 0,
    parameter int CTRL_W   = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic [CTRL_W-1:0] req_ctrl_0,
    input  logic [DATA_W-1:0] req_a_0,
    input  logic [DATA_W-1:0] req_b_0,
    input  logic [4:0]        req_shamt_0,

    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic [CTRL_W-1:0] req_ctrl_1,
    input  logic [DATA_W-1:0] req_a_1,
    input  logic [DATA_W-1:0] req_b_1,
    input  logic [4:0]        req_shamt_1,

    output logic              resp_valid_0,
    input  logic              resp_ready_0,
    output logic              resp_valid_1,
    input  logic              resp_ready_1,
    output logic [DATA_W-1:0] resp_r,
    output logic              resp_cout,
    output logic              resp_ovf,
    output logic              resp_ze,
    output logic              resp_err,

    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_cout,
    input  logic              alu_ovf,
    input  logic              alu_ze
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic                last_grant_q;
    logic                owner_q;
    logic [CTRL_W-1:0]   alu_ctrl_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic [4:0]          alu_shamt_q;
    logic [DATA_W-1:0]   resp_r_q;
    logic                resp_cout_q;
    logic                resp_ovf_q;
    logic                resp_ze_q;
    logic                resp_valid_0_q;
    logic                resp_valid_1_q;

    logic                grant_d;
    logic                accept_d;
    logic [CTRL_W-1:0]   sel_ctrl_d;
    logic [DATA_W-1:0]   sel_a_d;
    logic [DATA_W-1:0]   sel_b_d;
    logic [4:0]          sel_shamt_d;
    logic                resp_rdy_own_d;

    // Tie-break: round-robin picks the port that did not win last, fixed
    // priority always picks port 0. A lone valid request always wins.
    always_comb begin
        if (req_valid_0 && req_valid_1) begin
            grant_d = (ARB_MODE == 1) ? 1'b0 : ~last_grant_q;
        end else begin
            grant_d = ~req_valid_0;
        end
    end

    assign accept_d    = (state_q == IDLE) && (req_valid_0 || req_valid_1);
    assign req_ready_0 = (state_q == IDLE) && req_valid_0 && !grant_d;
    assign req_ready_1 = (state_q == IDLE) && req_valid_1 &&  grant_d;

    assign sel_ctrl_d  = grant_d ? req_ctrl_1  : req_ctrl_0;
    assign sel_a_d     = grant_d ? req_a_1     : req_a_0;
    assign sel_b_d     = grant_d ? req_b_1     : req_b_0;
    assign sel_shamt_d = grant_d ? req_shamt_1 : req_shamt_0;

    // Only the owner's ready can release the response.
    assign resp_rdy_own_d = owner_q ? resp_ready_1 : resp_ready_0;

`ifdef ALU_SHARE_ARB_ILLEGAL_CHK_EN
    logic resp_err_q;
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            alu_ctrl_q     <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_shamt_q    <= '0;
            resp_r_q       <= '0;
            resp_cout_q    <= 1'b0;
            resp_ovf_q     <= 1'b0;
            resp_ze_q      <= 1'b0;
            resp_valid_0_q <= 1'b0;
            resp_valid_1_q <= 1'b0;
`ifdef ALU_SHARE_ARB_ILLEGAL_CHK_EN
            resp_err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
`ifdef ALU_SHARE_ARB_ILLEGAL_CHK_EN
                        // Illegal codes never reach the ALU; answer directly
                        // with a zeroed result and the error flag.
                        if (sel_ctrl_d[3]) begin
                            resp_r_q       <= '0;
                            resp_cout_q    <= 1'b0;
                            resp_ovf_q     <= 1'b0;
                            resp_ze_q      <= 1'b0;
                            resp_err_q     <= 1'b1;
                            resp_valid_0_q <= ~grant_d;
                            resp_valid_1_q <=  grant_d;
                            state_q        <= RESP;
                        end else
`endif
                        begin
                            alu_ctrl_q  <= sel_ctrl_d;
                            alu_a_q     <= sel_a_d;
                            alu_b_q     <= sel_b_d;
                            alu_shamt_q <= sel_shamt_d;
                            state_q     <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // ALU has had a full cycle to settle on the registered operands.
                    resp_r_q       <= alu_r;
                    resp_cout_q    <= alu_cout;
                    resp_ovf_q     <= alu_ovf;
                    resp_ze_q      <= alu_ze;
`ifdef ALU_SHARE_ARB_ILLEGAL_CHK_EN
                    resp_err_q     <= 1'b0;
`endif
                    resp_valid_0_q <= ~owner_q;
                    resp_valid_1_q <=  owner_q;
                    state_q        <= RESP;
                end
                RESP: begin
                    if (resp_rdy_own_d) begin
                        resp_valid_0_q <= 1'b0;
                        resp_valid_1_q <= 1'b0;
`ifdef ALU_SHARE_ARB_ILLEGAL_CHK_EN
                        resp_err_q     <= 1'b0;
`endif
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_ctrl     = alu_ctrl_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_shamt    = alu_shamt_q;
    assign resp_r       = resp_r_q;
    assign resp_cout    = resp_cout_q;
    assign resp_ovf     = resp_ovf_q;
    assign resp_ze      = resp_ze_q;
    assign resp_valid_0 = resp_valid_0_q;
    assign resp_valid_1 = resp_valid_1_q;

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single combinational ALU between two requesters.
  - Port 0: EX-stage issue logic.
  - Port 1: multi-cycle helper unit, e.g. mult/div sequencer or address generator.
- Arbitrates and registers the selected operands onto the ALU inputs.
- Captures the ALU result and flags one cycle later.
- Returns them to the winning requester through a valid/ready response handshake.

Parameters:
- ARB_MODE, 0: 0 = round-robin between ports; 1 = fixed priority, port 0 always wins ties.
- CTRL_W, 4: width of the ALU operation select.
- DATA_W, 32: operand/result width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid_0  in  1  port 0 request valid
- req_ready_0  out  1  port 0 request accepted this cycle
- req_ctrl_0  in  CTRL_W  port 0 ALU op (0 and, 1 or, 2 add, 3 slt, 4 addu, 5 sll, 6 sub, 7 sltu)
- req_a_0  in  DATA_W  port 0 operand A
- req_b_0  in  DATA_W  port 0 operand B
- req_shamt_0  in  5  port 0 shift amount
- req_valid_1, req_ready_1, req_ctrl_1, req_a_1, req_b_1, req_shamt_1: same as port 0, for port 1
- resp_valid_0  out  1  port 0 result valid
- resp_ready_0  in  1  port 0 consumes result
- resp_valid_1  out  1  port 1 result valid
- resp_ready_1  in  1  port 1 consumes result
- resp_r  out  DATA_W  result, shared by both ports, qualified by resp_valid_x
- resp_cout  out  1  captured carry/borrow
- resp_ovf  out  1  captured overflow
- resp_ze  out  1  captured zero flag
- resp_err  out  1  illegal-op indication (optional feature only; else tied 0)
- alu_ctrl  out  CTRL_W  to ALU ctrl
- alu_a  out  DATA_W  to ALU A
- alu_b  out  DATA_W  to ALU B
- alu_shamt  out  5  to ALU shamt
- alu_r  in  DATA_W  from ALU R
- alu_cout  in  1  from ALU cout
- alu_ovf  in  1  from ALU ovf
- alu_ze  in  1  from ALU ze

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - All alu_* outputs 0.
  - All resp_* outputs 0.
  - req_ready_x 0.
  - State IDLE; last_grant = 1, so port 0 wins the first tie.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant computed combinationally from req_valid_0/1.
  - Only the granted port sees req_ready_x = 1; the other port sees 0.
  - On handshake (valid & ready), register the granted ctrl/a/b/shamt into alu_*, record the grant owner and go to EXEC.
  - No valid: stay in IDLE; alu_* hold their last values.
- EXEC: one cycle for the ALU to settle. At the end of EXEC, capture alu_r/cout/ovf/ze into the resp_* registers, then go to RESP.
- RESP:
  - resp_valid_owner = 1; resp_* stable until resp_ready_owner = 1.
  - On resp_ready, the next state is IDLE and resp_valid drops the next cycle.
  - No new request is accepted in RESP.
- Latency and throughput: accept in cycle N; resp_valid is high in cycle N+2. Minimum issue interval is 3 cycles.
- Arbitration:
  - A single valid request always wins.
  - Both valid, ARB_MODE=0: the port not equal to last_grant wins; last_grant updates on each handshake.
  - Both valid, ARB_MODE=1: port 0 wins.
- The losing requester must hold req_valid and its operands stable until it is accepted. The block does not latch rejected requests.
- Only the owner's resp_valid ever asserts. The non-owner's resp_ready is ignored.
- A requester may deassert req_valid before it is accepted; no side effect.
- Reset mid-operation: an in-flight op is dropped, no response is produced, all outputs return to their reset values.
- resp_* values are don't-care when no resp_valid is high, but the registers hold their last capture.

Optional Feature:
- Macro: ALU_SHARE_ARB_ILLEGAL_CHK_EN.
- Defined:
  - A request with ctrl[3] = 1 (codes 8-15) is accepted normally but skips EXEC: IDLE -> RESP directly.
  - resp_err = 1, resp_r = 0, flags = 0; alu_* are not updated.
  - resp_err clears when the response is consumed.
- Undefined: codes 8-15 pass through to the ALU unchanged and resp_err is constant 0.

Test Plan:
- Reset then single port 0 add: A=5, B=7, ctrl=2 -> req_ready_0 high in the same cycle; resp_valid_0 two cycles later; resp_r=12, cout=0, ovf=0, ze=0.
- Port 1 signed overflow: ctrl=2, A=0x7FFFFFFF, B=1 -> resp_valid_1; resp_r=0x80000000, ovf=1. Sub with A=B=9, ctrl=6 -> resp_r=0, ze=1.
- Both ports valid continuously, ARB_MODE=0 -> grants alternate 0,1,0,1. With ARB_MODE=1 -> port 0 granted every time and port 1 starves while port 0 stays valid.
- Response backpressure: hold resp_ready_0=0 for 5 cycles with port 1 valid -> resp_r stable; req_ready_1 stays 0 until resp_ready_0 pulses, then port 1 is granted in the following IDLE cycle.
- Assert rst_n=0 during EXEC of a sll op (A=1, shamt=4) -> no resp_valid ever appears for it; all outputs 0; the next request after reset is served normally.
- With ALU_SHARE_ARB_ILLEGAL_CHK_EN defined, ctrl=9 -> resp_valid one cycle after accept, resp_err=1, resp_r=0, alu_ctrl unchanged. Without the macro -> normal 2-cycle latency and resp_err=0.
